// File: rtl/mux_0.sv
// 2:1 bit-wise selector built from NAND-equivalent terms, plus registered copy and sel-toggle status.
// out is combinational (0 cycles), out_q/sel_toggles/toggled update 1 cycle after the inputs; no backpressure.
module mux_0 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] sel_toggles,
  output logic             toggled
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sel_n;
  logic [WIDTH-1:0] sel_vec;
  logic [WIDTH-1:0] sel_n_vec;
  logic [WIDTH-1:0] nand_a;
  logic [WIDTH-1:0] nand_b;
  logic             sel_prev;

  // Inverter realised as a NAND with both inputs tied together.
  assign sel_n     = ~(sel & sel);
  assign sel_vec   = {WIDTH{sel}};
  assign sel_n_vec = {WIDTH{sel_n}};
  assign nand_a    = ~(a & sel_n_vec);
  assign nand_b    = ~(b & sel_vec);
  assign out       = ~(nand_a & nand_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      sel_toggles <= '0;
      toggled     <= 1'b0;
      sel_prev    <= 1'b0;
    end else begin
      out_q    <= out;
      sel_prev <= sel;
      if (sel != sel_prev) begin
        toggled <= 1'b1;
        // Saturate rather than wrap so a long-running count is never misread as small.
        if (sel_toggles != CNT_MAX) begin
          sel_toggles <= sel_toggles + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_0.sv
// Directed bench for mux_0: an 8-bit instance and a 1-bit instance with a 2-bit toggle counter.
module tb_mux_0;

  logic       clk;
  logic       rst;
  logic [7:0] a8, b8;
  logic       sel8;
  logic [7:0] out8, out_q8;
  logic [7:0] tog8;
  logic       tgd8;
  logic [0:0] a1, b1;
  logic       sel1;
  logic [0:0] out1, out_q1;
  logic [1:0] tog1;
  logic       tgd1;

  int checks   = 0;
  int failures = 0;

  mux_0 #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel8),
    .out(out8), .out_q(out_q8), .sel_toggles(tog8), .toggled(tgd8)
  );

  mux_0 #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1),
    .out(out1), .out_q(out_q1), .sel_toggles(tog1), .toggled(tgd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sel8 = 1'b0; a1 = 1'b1; b1 = 1'b1; sel1 = 1'b0;
    tick();
    checks++;
    if (out_q8 !== 8'h00 || tog8 !== 8'h00 || tgd8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w8: out_q=%h toggles=%h toggled=%b, required 00/00/0", out_q8, tog8, tgd8);
    end
    checks++;
    if (out_q1 !== 1'b0 || tog1 !== 2'd0 || tgd1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w1: out_q=%b toggles=%0d toggled=%b, required 0/0/0", out_q1, tog1, tgd1);
    end
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [7:0] table_exp;
    logic [2:0] v;
    table_exp = 8'b1101_1000;  // bit index = {a,b,sel}
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; sel1 = v[0];
      #10;
      checks++;
      if (out1 !== table_exp[i]) begin
        failures++;
        $display("FAIL truth_abs=%b%b%b: out=%b, required %b", v[2], v[1], v[0], out1, table_exp[i]);
      end
    end
  endtask

  task automatic test_wide();
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0;
    #1;
    checks++;
    if (out8 !== 8'hA5) begin
      failures++;
      $display("FAIL wide_sel0: out=%h, required a5", out8);
    end
    sel8 = 1'b1;
    #1;
    checks++;
    if (out8 !== 8'h3C) begin
      failures++;
      $display("FAIL wide_sel1: out=%h, required 3c", out8);
    end
    a8 = 8'h0F; b8 = 8'hF0; sel8 = 1'b0;
    #1;
    checks++;
    if (out8 !== 8'h0F) begin
      failures++;
      $display("FAIL wide_sel0_b: out=%h, required 0f", out8);
    end
  endtask

  task automatic test_latency();
    rst = 1'b1; a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0;
    tick();
    checks++;
    if (out_q1 !== 1'b0) begin
      failures++;
      $display("FAIL lat_in_reset: out_q=%b, required 0", out_q1);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out_q1 !== 1'b1) begin
      failures++;
      $display("FAIL lat_first: out_q=%b, required 1", out_q1);
    end
    sel1 = 1'b1;
    #1;
    checks++;
    if (out1 !== 1'b0 || out_q1 !== 1'b1) begin
      failures++;
      $display("FAIL lat_comb: out=%b out_q=%b, required 0/1", out1, out_q1);
    end
    tick();
    checks++;
    if (out_q1 !== 1'b0) begin
      failures++;
      $display("FAIL lat_second: out_q=%b, required 0", out_q1);
    end
  endtask

  task automatic test_toggles();
    logic seq [4];
    seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; sel8 = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel8 = seq[i];
      tick();
      if (i == 0) begin
        checks++;
        if (tog8 !== 8'd0 || tgd8 !== 1'b0) begin
          failures++;
          $display("FAIL tog_no_change: toggles=%0d toggled=%b, required 0/0", tog8, tgd8);
        end
      end
    end
    checks++;
    if (tog8 !== 8'd3 || tgd8 !== 1'b1) begin
      failures++;
      $display("FAIL tog_count: toggles=%0d toggled=%b, required 3/1", tog8, tgd8);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (tog8 !== 8'd3 || tgd8 !== 1'b1) begin
      failures++;
      $display("FAIL tog_hold: toggles=%0d toggled=%b, required 3/1", tog8, tgd8);
    end
  endtask

  task automatic test_first_after_reset();
    rst = 1'b1; sel8 = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (tog8 !== 8'd1 || tgd8 !== 1'b1) begin
      failures++;
      $display("FAIL first_edge: toggles=%0d toggled=%b, required 1/1", tog8, tgd8);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1; sel1 = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sel1 = ~sel1;
      tick();
      if (i == 1) begin
        checks++;
        if (tog1 !== 2'd2) begin
          failures++;
          $display("FAIL sat_mid: toggles=%0d, required 2", tog1);
        end
      end
    end
    checks++;
    if (tog1 !== 2'd3 || tgd1 !== 1'b1) begin
      failures++;
      $display("FAIL sat_end: toggles=%0d toggled=%b, required 3/1", tog1, tgd1);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; sel8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    tick();
    rst = 1'b0;
    sel8 = 1'b1;
    tick();
    sel8 = 1'b0;
    tick();
    checks++;
    if (tog8 !== 8'd2 || tgd8 !== 1'b1 || out_q8 !== 8'h11) begin
      failures++;
      $display("FAIL mid_pre: toggles=%0d toggled=%b out_q=%h, required 2/1/11", tog8, tgd8, out_q8);
    end
    rst = 1'b1; sel8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3;
    tick();
    checks++;
    if (out_q8 !== 8'h00 || tog8 !== 8'd0 || tgd8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: out_q=%h toggles=%0d toggled=%b, required 00/0/0", out_q8, tog8, tgd8);
    end
    checks++;
    if (out8 !== 8'hC3) begin
      failures++;
      $display("FAIL mid_comb: out=%h, required c3", out8);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (tog8 !== 8'd1 || tgd8 !== 1'b1 || out_q8 !== 8'hC3) begin
      failures++;
      $display("FAIL mid_resume: toggles=%0d toggled=%b out_q=%h, required 1/1/c3", tog8, tgd8, out_q8);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_wide();
    test_latency();
    test_toggles();
    test_first_after_reset();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
